// File: rtl/axi_sram_slave_if.sv
// AXI4 read/write channel bundle between the CPU-side master and axi_sram_slave.
interface axi_sram_slave_if #(
    parameter int ID_W = 8
);
    logic [ID_W-1:0] ARID;
    logic [31:0]     ARADDR;
    logic [3:0]      ARLEN;
    logic [2:0]      ARSIZE;
    logic [1:0]      ARBURST;
    logic            ARVALID;
    logic            ARREADY;

    logic [ID_W-1:0] AWID;
    logic [31:0]     AWADDR;
    logic [3:0]      AWLEN;
    logic [2:0]      AWSIZE;
    logic [1:0]      AWBURST;
    logic            AWVALID;
    logic            AWREADY;

    logic [31:0]     WDATA;
    logic [3:0]      WSTRB;
    logic            WLAST;
    logic            WVALID;
    logic            WREADY;

    logic [ID_W-1:0] BID;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;

    logic [ID_W-1:0] RID;
    logic [31:0]     RDATA;
    logic [1:0]      RRESP;
    logic            RLAST;
    logic            RVALID;
    logic            RREADY;

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave driving a single-port synchronous SRAM; INCR/FIXED bursts up to 16 beats.
// Define AXI_SRAM_RANGE_CHECK_EN to answer DECERR for addresses above the SRAM size.
module axi_sram_slave #(
    parameter int ID_W    = 8,
    parameter int SRAM_AW = 14
) (
    input  logic               clk,
    input  logic               rst,
    axi_sram_slave_if.slave    axi,
    output logic               SRAM_CS,
    output logic               SRAM_OE,
    output logic [3:0]         SRAM_WEB,
    output logic [SRAM_AW-1:0] SRAM_A,
    output logic [31:0]        SRAM_DI,
    input  logic [31:0]        SRAM_DO
);
    typedef enum logic [2:0] {IDLE, R_ISSUE, R_DATA, W_DATA, W_RESP} state_t;

    state_t             state, next_state;
    logic               init_done;
    logic [ID_W-1:0]    id_q;
    logic [SRAM_AW-1:0] addr_q;
    logic [3:0]         len_q, cnt_q;
    logic               fixed_q, over_q, mismatch_q, r_first_q;
    logic [31:0]        rdata_q;
    logic               range_err;
    logic               ar_hs, aw_hs, r_hs, w_hs, at_last;

    assign ar_hs   = (state == IDLE) && init_done && axi.ARVALID;
    assign aw_hs   = (state == IDLE) && init_done && !axi.ARVALID && axi.AWVALID;
    assign r_hs    = (state == R_DATA) && axi.RREADY;
    assign w_hs    = (state == W_DATA) && axi.WVALID;
    assign at_last = (cnt_q == len_q);

`ifdef AXI_SRAM_RANGE_CHECK_EN
    logic range_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       range_err_q <= 1'b0;
        else if (ar_hs) range_err_q <= |axi.ARADDR[31:SRAM_AW+2];
        else if (aw_hs) range_err_q <= |axi.AWADDR[31:SRAM_AW+2];
    end

    assign range_err = range_err_q;
`else
    assign range_err = 1'b0;
`endif

    // Size is always treated as 4 bytes and upper address bits alias by default.
    logic unused_bits;
    assign unused_bits = ^{axi.ARSIZE, axi.AWSIZE, axi.ARADDR[1:0], axi.AWADDR[1:0],
                           axi.ARADDR[31:SRAM_AW+2], axi.AWADDR[31:SRAM_AW+2]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state    = state;
        axi.ARREADY   = 1'b0;
        axi.AWREADY   = 1'b0;
        axi.WREADY    = 1'b0;
        axi.RVALID    = 1'b0;
        axi.RLAST     = 1'b0;
        axi.RRESP     = 2'b00;
        axi.BVALID    = 1'b0;
        axi.BRESP     = 2'b00;
        SRAM_CS       = 1'b0;
        SRAM_OE       = 1'b0;
        SRAM_WEB      = 4'hF;
        SRAM_DI       = '0;
        case (state)
            IDLE: begin
                axi.ARREADY = init_done;
                axi.AWREADY = init_done && !axi.ARVALID;
                if (ar_hs)      next_state = R_ISSUE;
                else if (aw_hs) next_state = W_DATA;
            end
            R_ISSUE: begin
                SRAM_CS    = !range_err;
                SRAM_OE    = !range_err;
                next_state = R_DATA;
            end
            R_DATA: begin
                axi.RVALID = 1'b1;
                axi.RLAST  = at_last;
                axi.RRESP  = range_err ? 2'b11 : 2'b00;
                if (r_hs) next_state = at_last ? IDLE : R_ISSUE;
            end
            W_DATA: begin
                axi.WREADY = 1'b1;
                if (w_hs && !over_q && !range_err) begin
                    SRAM_CS  = 1'b1;
                    SRAM_WEB = ~axi.WSTRB;
                    SRAM_DI  = axi.WDATA;
                end
                if (w_hs && axi.WLAST) next_state = W_RESP;
            end
            W_RESP: begin
                axi.BVALID = 1'b1;
                axi.BRESP  = range_err ? 2'b11 : (mismatch_q ? 2'b10 : 2'b00);
                if (axi.BREADY) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // First R_DATA cycle forwards the SRAM output; later cycles replay the captured copy.
    assign axi.RDATA = r_first_q ? (range_err ? 32'h0 : SRAM_DO) : rdata_q;
    assign axi.RID   = id_q;
    assign axi.BID   = id_q;
    assign SRAM_A    = addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_done  <= 1'b0;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            fixed_q    <= 1'b0;
            over_q     <= 1'b0;
            mismatch_q <= 1'b0;
            r_first_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            init_done <= 1'b1;
            r_first_q <= (state == R_ISSUE);
            if (r_first_q) rdata_q <= range_err ? 32'h0 : SRAM_DO;
            if (ar_hs) begin
                id_q    <= axi.ARID;
                addr_q  <= axi.ARADDR[SRAM_AW+1:2];
                len_q   <= axi.ARLEN;
                fixed_q <= (axi.ARBURST == 2'b00);
                cnt_q   <= '0;
            end else if (aw_hs) begin
                id_q       <= axi.AWID;
                addr_q     <= axi.AWADDR[SRAM_AW+1:2];
                len_q      <= axi.AWLEN;
                fixed_q    <= (axi.AWBURST == 2'b00);
                cnt_q      <= '0;
                over_q     <= 1'b0;
                mismatch_q <= 1'b0;
            end else if (r_hs && !at_last) begin
                cnt_q <= cnt_q + 1'b1;
                if (!fixed_q) addr_q <= addr_q + 1'b1;
            end else if (w_hs) begin
                // over_q marks beats past len so they are acknowledged but never written.
                if (axi.WLAST) begin
                    if (!at_last || over_q) mismatch_q <= 1'b1;
                end else if (at_last) begin
                    over_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!fixed_q) addr_q <= addr_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave using a behavioural synchronous SRAM model.
module tb_axi_sram_slave;
    localparam int ID_W    = 8;
    localparam int SRAM_AW = 14;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               sram_cs, sram_oe;
    logic [3:0]         sram_web;
    logic [SRAM_AW-1:0] sram_a;
    logic [31:0]        sram_di;
    logic [31:0]        sram_do = 32'h0;
    logic [31:0]        mem [0:(1<<SRAM_AW)-1];
    logic               pre_we = 1'b0;
    logic [SRAM_AW-1:0] pre_a = '0;
    logic [31:0]        pre_d = '0;
    int                 tests = 0;
    int                 failed = 0;
    int                 cs_count = 0;

    axi_sram_slave_if #(.ID_W(ID_W)) bus();

    axi_sram_slave #(.ID_W(ID_W), .SRAM_AW(SRAM_AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .axi      (bus),
        .SRAM_CS  (sram_cs),
        .SRAM_OE  (sram_oe),
        .SRAM_WEB (sram_web),
        .SRAM_A   (sram_a),
        .SRAM_DI  (sram_di),
        .SRAM_DO  (sram_do)
    );

    always #5 clk = ~clk;

    // Read-before-write SRAM model plus a side port for preloading words.
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_a] <= pre_d;
        end else if (sram_cs) begin
            cs_count <= cs_count + 1;
            for (int b = 0; b < 4; b++)
                if (!sram_web[b]) mem[sram_a][8*b +: 8] <= sram_di[8*b +: 8];
            if (sram_oe) sram_do <= mem[sram_a];
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [SRAM_AW-1:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_a = a; pre_d = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
        int n = 0;
        bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = 3'b010;
        bus.ARBURST = burst; bus.ARVALID = 1'b1;
        #1;
        while (!bus.ARREADY && n < 20) begin @(posedge clk); #2; n++; end
        check_output("arready", bus.ARREADY, 1);
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
    endtask

    task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
        int n = 0;
        bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = 3'b010;
        bus.AWBURST = burst; bus.AWVALID = 1'b1;
        #1;
        while (!bus.AWREADY && n < 20) begin @(posedge clk); #2; n++; end
        check_output("awready", bus.AWREADY, 1);
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        bus.WDATA = data; bus.WSTRB = strb; bus.WLAST = last; bus.WVALID = 1'b1;
        #1;
        while (!bus.WREADY && n < 20) begin @(posedge clk); #2; n++; end
        check_output("wready", bus.WREADY, 1);
        @(posedge clk); #1;
        bus.WVALID = 1'b0;
    endtask

    task automatic recv_r(output logic [31:0] d, output logic [1:0] resp, output logic last, output logic [7:0] id);
        int n = 0;
        #1;
        while (!bus.RVALID && n < 20) begin @(posedge clk); #2; n++; end
        check_output("rvalid", bus.RVALID, 1);
        d = bus.RDATA; resp = bus.RRESP; last = bus.RLAST; id = bus.RID;
        bus.RREADY = 1'b1;
        @(posedge clk); #1;
        bus.RREADY = 1'b0;
    endtask

    task automatic recv_b(output logic [1:0] resp, output logic [7:0] id);
        int n = 0;
        #1;
        while (!bus.BVALID && n < 20) begin @(posedge clk); #2; n++; end
        check_output("bvalid", bus.BVALID, 1);
        resp = bus.BRESP; id = bus.BID;
        bus.BREADY = 1'b1;
        @(posedge clk); #1;
        bus.BREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  resp;
        logic        last;
        logic [7:0]  id;
        int          cs_before;

        bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = 3'b010; bus.ARBURST = 2'b01; bus.ARVALID = 1'b0;
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = 3'b010; bus.AWBURST = 2'b01; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;

        preload(14'h0004, 32'hDEADBEEF);
        preload(14'h0081, 32'h0000_0000);
        preload(14'h00C0, 32'h0000_0000);

        // Reset values while rst is held low.
        check_output("rst_arready", bus.ARREADY, 0);
        check_output("rst_awready", bus.AWREADY, 0);
        check_output("rst_wready",  bus.WREADY, 0);
        check_output("rst_rvalid",  bus.RVALID, 0);
        check_output("rst_bvalid",  bus.BVALID, 0);
        check_output("rst_cs",      sram_cs, 0);
        check_output("rst_oe",      sram_oe, 0);
        check_output("rst_web",     sram_web, 4'hF);
        check_output("rst_addr",    sram_a, 0);
        check_output("rst_rdata",   bus.RDATA, 0);
        check_output("rst_rid",     bus.RID, 0);
        check_output("rst_bid",     bus.BID, 0);

        @(negedge clk); rst = 1'b1; #1;
        check_output("init_pending", bus.ARREADY, 0);
        @(posedge clk); #1;
        check_output("init_arready", bus.ARREADY, 1);
        check_output("init_awready", bus.AWREADY, 1);

        // Single-beat read of word 4.
        send_ar(8'h12, 32'h0000_0010, 4'd0, 2'b01);
        recv_r(d, resp, last, id);
        check_output("rd1_data", d, 32'hDEADBEEF);
        check_output("rd1_id",   id, 8'h12);
        check_output("rd1_last", last, 1);
        check_output("rd1_resp", resp, 2'b00);

        // INCR write burst of 4 then read it back.
        send_aw(8'h34, 32'h0000_0100, 4'd3, 2'b01);
        send_w(32'd1, 4'hF, 1'b0);
        send_w(32'd2, 4'hF, 1'b0);
        send_w(32'd3, 4'hF, 1'b0);
        send_w(32'd4, 4'hF, 1'b1);
        recv_b(resp, id);
        check_output("wr_bresp", resp, 2'b00);
        check_output("wr_bid",   id, 8'h34);
        for (int i = 0; i < 4; i++) check_output("wr_mem", mem[14'h40 + i], i + 1);
        send_ar(8'h35, 32'h0000_0100, 4'd3, 2'b01);
        for (int i = 0; i < 4; i++) begin
            recv_r(d, resp, last, id);
            check_output("rb_data", d, i + 1);
            check_output("rb_last", last, (i == 3) ? 1 : 0);
        end

        // Byte strobes merge new bytes 0 and 2 into the old word.
        send_aw(8'h01, 32'h0000_0140, 4'd0, 2'b01);
        send_w(32'h11223344, 4'hF, 1'b1);
        recv_b(resp, id);
        send_aw(8'h02, 32'h0000_0140, 4'd0, 2'b01);
        send_w(32'hAABBCCDD, 4'b0101, 1'b1);
        recv_b(resp, id);
        send_ar(8'h03, 32'h0000_0140, 4'd0, 2'b01);
        recv_r(d, resp, last, id);
        check_output("strb_data", d, 32'h11BB33DD);

        // FIXED burst keeps hitting the same word.
        send_aw(8'h05, 32'h0000_0200, 4'd1, 2'b00);
        send_w(32'h0000_000A, 4'hF, 1'b0);
        send_w(32'h0000_000B, 4'hF, 1'b1);
        recv_b(resp, id);
        check_output("fixed_bresp", resp, 2'b00);
        check_output("fixed_w0",    mem[14'h80], 32'h0000_000B);
        check_output("fixed_w1",    mem[14'h81], 32'h0000_0000);

        // Simultaneous AR/AW: read wins, R held under backpressure, AW waits.
        bus.ARID = 8'h21; bus.ARADDR = 32'h0000_0100; bus.ARLEN = 4'd0; bus.ARBURST = 2'b01; bus.ARVALID = 1'b1;
        bus.AWID = 8'h22; bus.AWADDR = 32'h0000_0300; bus.AWLEN = 4'd0; bus.AWBURST = 2'b01; bus.AWVALID = 1'b1;
        #1;
        check_output("prio_arready", bus.ARREADY, 1);
        check_output("prio_awready", bus.AWREADY, 0);
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
        #1;
        check_output("prio_aw_blocked", bus.AWREADY, 0);
        @(posedge clk); #2;
        for (int k = 0; k < 5; k++) begin
            check_output("bp_rvalid", bus.RVALID, 1);
            check_output("bp_rdata",  bus.RDATA, 32'd1);
            check_output("bp_awready", bus.AWREADY, 0);
            @(posedge clk); #2;
        end
        recv_r(d, resp, last, id);
        check_output("bp_data", d, 32'd1);
        check_output("bp_id",   id, 8'h21);
        #1;
        check_output("bp_aw_after", bus.AWREADY, 1);
        send_aw(8'h22, 32'h0000_0300, 4'd0, 2'b01);
        send_w(32'h5A5A5A5A, 4'hF, 1'b1);
        recv_b(resp, id);
        check_output("bp_bid", id, 8'h22);
        check_output("bp_mem", mem[14'hC0], 32'h5A5A5A5A);

        // WLAST on beat 2 of a 4-beat burst.
        send_aw(8'h44, 32'h0000_0180, 4'd3, 2'b01);
        send_w(32'd7, 4'hF, 1'b0);
        send_w(32'd8, 4'hF, 1'b1);
        recv_b(resp, id);
        check_output("early_bresp", resp, 2'b10);

        // Reset in the middle of a read burst.
        send_ar(8'h55, 32'h0000_0100, 4'd3, 2'b01);
        recv_r(d, resp, last, id);
        check_output("mid_beat0", d, 32'd1);
        #2; rst = 1'b0; #1;
        check_output("mid_rvalid",  bus.RVALID, 0);
        check_output("mid_arready", bus.ARREADY, 0);
        check_output("mid_cs",      sram_cs, 0);
        check_output("mid_oe",      sram_oe, 0);
        check_output("mid_rid",     bus.RID, 0);
        check_output("mid_addr",    sram_a, 0);
        @(posedge clk); #1;
        check_output("mid_rvalid_edge", bus.RVALID, 0);
        check_output("mid_rdata_edge",  bus.RDATA, 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        send_ar(8'h66, 32'h0000_0010, 4'd0, 2'b01);
        recv_r(d, resp, last, id);
        check_output("post_rst_data", d, 32'hDEADBEEF);
        check_output("post_rst_id",   id, 8'h66);
        check_output("post_rst_last", last, 1);

        // Address above the SRAM: DECERR with range checking, alias otherwise.
        cs_before = cs_count;
        send_ar(8'h77, 32'h0001_0010, 4'd0, 2'b01);
        recv_r(d, resp, last, id);
`ifdef AXI_SRAM_RANGE_CHECK_EN
        check_output("range_rresp", resp, 2'b11);
        check_output("range_rdata", d, 32'h0);
        check_output("range_cs",    cs_count, cs_before);
        send_aw(8'h78, 32'h0001_0300, 4'd0, 2'b01);
        send_w(32'h12345678, 4'hF, 1'b1);
        recv_b(resp, id);
        check_output("range_bresp", resp, 2'b11);
        check_output("range_mem",   mem[14'hC0], 32'h5A5A5A5A);
`else
        check_output("alias_rresp", resp, 2'b00);
        check_output("alias_rdata", d, 32'hDEADBEEF);
        check_output("alias_cs",    cs_count, cs_before + 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
